// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache fills, D-cache fills and D-cache write-throughs.
// A fill issues CHUNKS back-to-back reads and routes the returning words to the owning cache.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int CHUNKS      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_data_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_grant,
  output logic        d_data_valid,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [2:0]  fill_idx,
  output logic        fill_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid
);

  typedef enum logic [1:0] {IDLE, WRITE, I_FILL, D_FILL} state_t;

  localparam logic [3:0] ISSUE_END = 4'(CHUNKS);
  localparam logic [2:0] RET_LAST  = 3'(CHUNKS - 1);
  // Return timing is taken from mem_data_valid, so the latency only documents the memory.
  localparam int unused_mem_latency = MEM_LATENCY;

  state_t      state_reg, state_next;
  logic [3:0]  issue_cnt_reg;
  logic [2:0]  ret_cnt_reg;
  logic [11:0] base_reg;
  logic        last_fill_d_reg;
  logic        in_fill;
  logic        issuing;
  logic        last_word;
  logic        unused_addr_bits;

  // Offset-within-block bits never reach memory: fills always start at the block base.
  assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

  assign in_fill   = (state_reg == I_FILL) || (state_reg == D_FILL);
  assign issuing   = in_fill && (issue_cnt_reg < ISSUE_END);
  assign last_word = in_fill && mem_data_valid && (ret_cnt_reg == RET_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_reg   <= 4'd0;
      ret_cnt_reg     <= 3'd0;
      base_reg        <= 12'd0;
      last_fill_d_reg <= 1'b1;
    end else if (in_fill) begin
      if (issuing) begin
        issue_cnt_reg <= issue_cnt_reg + 4'd1;
      end
      if (mem_data_valid) begin
        ret_cnt_reg <= ret_cnt_reg + 3'd1;
      end
      if (last_word) begin
        last_fill_d_reg <= ~last_fill_d_reg;
      end
    end else begin
      issue_cnt_reg <= 4'd0;
      ret_cnt_reg   <= 3'd0;
      if (state_next == I_FILL) begin
        base_reg <= i_addr[15:4];
      end else if (state_next == D_FILL) begin
        base_reg <= d_addr[15:4];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (wr_req) begin
          state_next = WRITE;
        end else if (i_req && d_req) begin
          state_next = last_fill_d_reg ? I_FILL : D_FILL;
        end else if (i_req) begin
          state_next = I_FILL;
        end else if (d_req) begin
          state_next = D_FILL;
        end
      end
      WRITE:          state_next = IDLE;
      I_FILL, D_FILL: if (last_word) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    wr_ack       = 1'b0;
    fill_idx     = ret_cnt_reg;
    fill_done    = last_word;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    case (state_reg)
      WRITE: begin
        wr_ack    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      I_FILL, D_FILL: begin
        i_grant      = (state_reg == I_FILL);
        d_grant      = (state_reg == D_FILL);
        i_data_valid = (state_reg == I_FILL) && mem_data_valid;
        d_data_valid = (state_reg == D_FILL) && mem_data_valid;
        mem_en       = issuing;
        if (issuing) begin
          mem_addr = {base_reg, 4'h0} + {11'h000, issue_cnt_reg, 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int CH  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, wr_req;
  logic [15:0] i_addr, d_addr, wr_addr, wr_data;
  logic        i_grant, i_data_valid, d_grant, d_data_valid, wr_ack;
  logic [2:0]  fill_idx;
  logic        fill_done, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(LAT), .CHUNKS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant), .d_data_valid(d_data_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_idx(fill_idx), .fill_done(fill_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ret_q[$];          // cycles at which the memory will return a read word
  bit stray_en = 1'b0;   // inject spurious mem_data_valid while the model is idle

  // Transaction-level model: 0 idle, 1 write, 2 I fill, 3 D fill
  int          m_mode;
  logic [15:0] m_base;
  int          m_k, m_words;
  bit          m_last_d;

  int cnt_i_dv, cnt_d_dv, cnt_igrant;
  int ev_seq[$];         // 3 = write, 1 = I grant start, 2 = D grant start
  bit prev_i, prev_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_words = 0; m_last_d = 1'b1;
  endtask

  task automatic tick();
    bit fill, exp_en;
    @(negedge clk);
    if (!rst_n) model_reset();
    fill   = (m_mode >= 2);
    exp_en = (m_mode == 1) || (fill && m_k < CH);
    chk("grant",      32'({i_grant, d_grant}), 32'({m_mode == 2, m_mode == 3}));
    chk("data_valid", 32'({i_data_valid, d_data_valid}),
        32'({m_mode == 2 && mem_data_valid, m_mode == 3 && mem_data_valid}));
    chk("fill_idx",   32'(fill_idx), fill ? 32'(m_words % CH) : 32'd0);
    chk("fill_done",  32'(fill_done), 32'(fill && mem_data_valid && m_words == CH - 1));
    chk("wr_ack",     32'(wr_ack), 32'(m_mode == 1));
    chk("mem_en_wr",  32'({mem_en, mem_wr}), 32'({exp_en, m_mode == 1}));
    chk("mem_wdata",  32'(mem_wdata), (m_mode == 1) ? 32'(wr_data) : 32'd0);
    if (exp_en)
      chk("mem_addr", 32'(mem_addr), (m_mode == 1) ? 32'(wr_addr) : 32'(m_base + 16'(2 * m_k)));
    cnt_i_dv   += int'(i_data_valid);
    cnt_d_dv   += int'(d_data_valid);
    cnt_igrant += int'(i_grant);
    if (wr_ack) ev_seq.push_back(3);
    if (i_grant && !prev_i) ev_seq.push_back(1);
    if (d_grant && !prev_d) ev_seq.push_back(2);
    prev_i = i_grant; prev_d = d_grant;
    if (mem_en && !mem_wr) ret_q.push_back(cyc + LAT - 1);
    if (rst_n) begin
      case (m_mode)
        0: begin
          if (wr_req) m_mode = 1;
          else if (i_req && (!d_req || m_last_d)) begin
            m_mode = 2; m_base = {i_addr[15:4], 4'h0}; m_k = 0; m_words = 0;
          end else if (d_req) begin
            m_mode = 3; m_base = {d_addr[15:4], 4'h0}; m_k = 0; m_words = 0;
          end
        end
        1: m_mode = 0;
        default: begin
          m_k++;
          if (mem_data_valid) m_words++;
          if (m_words == CH) begin
            m_mode = 0; m_last_d = !m_last_d;
          end
        end
      endcase
    end
    @(posedge clk); #1;
    cyc++;
    mem_data_valid = stray_en && (m_mode == 0) && ($urandom_range(0, 2) == 0);
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      mem_data_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; wr_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] obs;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; wr_req = 1'b0; mem_data_valid = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; wr_addr = 16'h0; wr_data = 16'h0;
    prev_i = 1'b0; prev_d = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single I fill from an unaligned address
    cnt_igrant = 0; cnt_i_dv = 0;
    i_req = 1'b1; i_addr = 16'h1236;
    tick();
    i_req = 1'b0;
    ticks(13);
    chk("ifill_cycles", 32'(cnt_igrant), 32'd11);
    chk("ifill_words",  32'(cnt_i_dv), 32'd8);

    // Write beats both fills, then I wins the first tie after reset
    do_reset();
    ev_seq.delete();
    wr_req = 1'b1; wr_addr = 16'hBEEF; wr_data = 16'h5A5A;
    i_req = 1'b1; i_addr = 16'h4000; d_req = 1'b1; d_addr = 16'h8010;
    tick();
    wr_req = 1'b0;
    ticks(14);
    i_req = 1'b0; d_req = 1'b0;
    ticks(13);
    obs = 8'h00;
    for (int i = 0; i < 3; i++) obs = {obs[5:0], (i < ev_seq.size()) ? 2'(ev_seq[i]) : 2'd0};
    chk("wr_i_d_order", 32'(obs), 32'(8'b00_11_01_10));

    // Continuous ties alternate I, D, I, D
    do_reset();
    ev_seq.delete();
    i_req = 1'b1; i_addr = 16'h0120; d_req = 1'b1; d_addr = 16'hF00F;
    ticks(4 * 12);
    i_req = 1'b0; d_req = 1'b0;
    ticks(13);
    obs = 8'h00;
    for (int i = 0; i < 4; i++) obs = {obs[5:0], (i < ev_seq.size()) ? 2'(ev_seq[i]) : 2'd0};
    chk("alternation", 32'(obs), 32'(8'b01_10_01_10));

    // D fill survives its request being dropped early
    cnt_i_dv = 0; cnt_d_dv = 0;
    d_req = 1'b1; d_addr = 16'h7FFE;
    tick(); tick();
    d_req = 1'b0; d_addr = 16'h0000;
    ticks(13);
    chk("dfill_words", 32'(cnt_d_dv), 32'd8);
    chk("dfill_no_i",  32'(cnt_i_dv), 32'd0);

    // Reset in the middle of a fill; late returns must be ignored
    i_req = 1'b1; i_addr = 16'h3330;
    tick();
    i_req = 1'b0;
    ticks(5);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'({i_grant, i_data_valid, d_grant, d_data_valid, wr_ack, fill_idx,
                         fill_done, mem_en, mem_wr}), 32'd0);
    chk("rst_bus",  32'({mem_addr, mem_wdata}), 32'd0);
    cnt_i_dv = 0; cnt_d_dv = 0;
    tick(); tick();
    rst_n = 1'b1;
    ticks(8);
    chk("late_returns", 32'(cnt_i_dv + cnt_d_dv), 32'd0);

    // Stray returns in IDLE, then a clean fill starting at word 0
    stray_en = 1'b1;
    ticks(8);
    stray_en = 1'b0;
    cnt_d_dv = 0;
    d_req = 1'b1; d_addr = 16'hA5A5;
    tick();
    d_req = 1'b0;
    ticks(13);
    chk("post_stray_words", 32'(cnt_d_dv), 32'd8);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!i_req) begin
        if ($urandom_range(0, 99) < 15) begin i_req = 1'b1; i_addr = 16'($urandom); end
      end else if ($urandom_range(0, 99) < 5) i_req = 1'b0;
      if (!d_req) begin
        if ($urandom_range(0, 99) < 15) begin d_req = 1'b1; d_addr = 16'($urandom); end
      end else if ($urandom_range(0, 99) < 5) d_req = 1'b0;
      wr_req  = ($urandom_range(0, 99) < 10);
      wr_addr = 16'($urandom);
      wr_data = 16'($urandom);
      stray_en = ($urandom_range(0, 3) == 0);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; wr_req = 1'b0; stray_en = 1'b0;
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
